// File: rtl/fdc_drive_pkg.sv
// Shared definitions for the floppy drive spindle emulator: spindle
// state encoding, RPM divisors and default parameter values.
package fdc_drive_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_SPINUP   = 2'd1,
        ST_AT_SPEED = 2'd2,
        ST_SPINDOWN = 2'd3
    } spindle_state_e;

    // One revolution is CLK_FREQ / divisor clocks (300 RPM -> 5 rev/s, 360 RPM -> 6 rev/s).
    localparam int unsigned RPM300_DIV = 5;
    localparam int unsigned RPM360_DIV = 6;

    localparam int unsigned DEF_CLK_FREQ         = 200_000_000;
    localparam int unsigned DEF_SPINUP_REVS      = 3;
    localparam int unsigned DEF_SPINDOWN_REVS    = 2;
    localparam int unsigned DEF_INDEX_PULSE_CLKS = 400_000;

endpackage

// File: rtl/index_pulse_shaper.sv
// Turns a one-cycle revolution strobe into the registered index_pulse
// strobe and the active-low index_n line held low for PULSE_CLKS cycles.
module index_pulse_shaper #(
    parameter int unsigned PULSE_CLKS = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic index_pulse,
    output logic index_n
);

    logic [31:0] low_cnt_q;

    // index_n drops together with index_pulse and rises after PULSE_CLKS cycles low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_pulse <= 1'b0;
            index_n     <= 1'b1;
            low_cnt_q   <= '0;
        end else begin
            index_pulse <= strobe;
            if (strobe) begin
                low_cnt_q <= 32'(PULSE_CLKS);
                index_n   <= 1'b0;
            end else if (low_cnt_q > 32'd1) begin
                low_cnt_q <= low_cnt_q - 32'd1;
            end else if (low_cnt_q == 32'd1) begin
                low_cnt_q <= '0;
                index_n   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/drive_spindle_emulator.sv
// Drive-side spindle model: motor_on drives a STOPPED/SPINUP/AT_SPEED/
// SPINDOWN sequence; a phase counter produces one revolution event per
// (nominal period + stretch) clocks, and the stretch shrinks or grows by
// a quarter period per revolution to emulate acceleration.
module drive_spindle_emulator
    import fdc_drive_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = DEF_CLK_FREQ,
    parameter int unsigned SPINUP_REVS      = DEF_SPINUP_REVS,
    parameter int unsigned SPINDOWN_REVS    = DEF_SPINDOWN_REVS,
    parameter int unsigned INDEX_PULSE_CLKS = DEF_INDEX_PULSE_CLKS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        motor_on,
    input  logic        rpm_sel,
    input  logic        disk_present,
    output logic        index_pulse,
    output logic        index_n,
    output logic        spinning,
    output logic        at_speed,
    output logic        ready,
    output logic [15:0] rev_count,
    output logic [1:0]  state_dbg
);

    localparam logic [31:0] P300  = 32'(CLK_FREQ / RPM300_DIV);
    localparam logic [31:0] P360  = 32'(CLK_FREQ / RPM360_DIV);
    // Full spin-up stretch is a constant per RPM setting, so no runtime multiply.
    localparam logic [31:0] SU300 = 32'(SPINUP_REVS) * (P300 >> 2);
    localparam logic [31:0] SU360 = 32'(SPINUP_REVS) * (P360 >> 2);

    spindle_state_e state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [31:0] stretch_q, stretch_d;
    logic [31:0] period_q, period_d;
    logic        rpm_q, rpm_d;
    logic [15:0] rev_count_q, rev_count_d;
    logic [3:0]  down_cnt_q, down_cnt_d;
    logic        at_speed_q, ready_q;

    logic [31:0] cur_period;
    logic        rev_event;
    logic [31:0] p_sel, su_sel, su_cur, q_new, stretch_capped;

    assign cur_period     = period_q + stretch_q;
    assign rev_event      = (state_q != ST_STOPPED) && (phase_q == cur_period - 32'd1);
    assign p_sel          = rpm_sel ? P360 : P300;
    assign su_sel         = rpm_sel ? SU360 : SU300;
    assign su_cur         = rpm_q ? SU360 : SU300;
    // Quarter of the period latched at this event; it sizes the next revolution.
    assign q_new          = p_sel >> 2;
    assign stretch_capped = (stretch_q > su_cur) ? su_cur : stretch_q;

    // Next-state logic: a motor_on change wins over a same-cycle event, whose
    // stretch update is then applied as the new state would apply it.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        stretch_d   = stretch_q;
        period_d    = period_q;
        rpm_d       = rpm_q;
        rev_count_d = rev_count_q;
        down_cnt_d  = down_cnt_q;

        if (state_q != ST_STOPPED) begin
            phase_d = rev_event ? 32'd0 : phase_q + 32'd1;
        end
        if (rev_event) begin
            period_d = p_sel;
            rpm_d    = rpm_sel;
        end

        case (state_q)
            ST_STOPPED: begin
                if (motor_on) begin
                    state_d     = ST_SPINUP;
                    stretch_d   = su_sel;
                    period_d    = p_sel;
                    rpm_d       = rpm_sel;
                    rev_count_d = '0;
                end
            end
            ST_SPINUP: begin
                if (!motor_on) begin
                    state_d    = ST_SPINDOWN;
                    down_cnt_d = '0;
                    if (rev_event) begin
                        stretch_d  = stretch_q + q_new;
                        down_cnt_d = 4'd1;
                    end
                end else if (rev_event) begin
                    if (stretch_q <= q_new) begin
                        stretch_d = '0;
                        state_d   = ST_AT_SPEED;
                    end else begin
                        stretch_d = stretch_q - q_new;
                    end
                end
            end
            ST_AT_SPEED: begin
                if (!motor_on) begin
                    state_d    = ST_SPINDOWN;
                    down_cnt_d = '0;
                    if (rev_event) begin
                        stretch_d  = stretch_q + q_new;
                        down_cnt_d = 4'd1;
                    end
                end else if (rev_event && (rev_count_q != 16'hFFFF)) begin
                    rev_count_d = rev_count_q + 16'd1;
                end
            end
            ST_SPINDOWN: begin
                if (motor_on) begin
                    state_d   = ST_SPINUP;
                    stretch_d = stretch_capped;
                    if (rev_event) begin
                        stretch_d = (stretch_capped <= q_new) ? 32'd0 : stretch_capped - q_new;
                    end
                end else if (rev_event) begin
                    // The in-progress revolution's event opens the stretched
                    // revolutions; the event after SPINDOWN_REVS of them stops.
                    if (down_cnt_q == 4'(SPINDOWN_REVS)) begin
                        state_d   = ST_STOPPED;
                        stretch_d = su_sel;
                    end else begin
                        down_cnt_d = down_cnt_q + 4'd1;
                        stretch_d  = stretch_q + q_new;
                    end
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // State, phase, stretch and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_STOPPED;
            phase_q     <= '0;
            stretch_q   <= SU300;
            period_q    <= P300;
            rpm_q       <= 1'b0;
            rev_count_q <= '0;
            down_cnt_q  <= '0;
            at_speed_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stretch_q   <= stretch_d;
            period_q    <= period_d;
            rpm_q       <= rpm_d;
            rev_count_q <= rev_count_d;
            down_cnt_q  <= down_cnt_d;
            at_speed_q  <= (state_q == ST_AT_SPEED);
            ready_q     <= (state_q == ST_AT_SPEED) && disk_present;
        end
    end

    index_pulse_shaper #(
        .PULSE_CLKS(INDEX_PULSE_CLKS)
    ) u_shaper (
        .clk        (clk),
        .reset_n    (reset_n),
        .strobe     (rev_event && disk_present),
        .index_pulse(index_pulse),
        .index_n    (index_n)
    );

    assign spinning  = (state_q != ST_STOPPED);
    assign at_speed  = at_speed_q;
    assign ready     = ready_q;
    assign rev_count = rev_count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_drive_spindle_emulator.sv
// Directed bench for drive_spindle_emulator with CLK_FREQ=1000
// (P=200 at 300 RPM, P=166 at 360 RPM, Q=50), SPINUP_REVS=3,
// SPINDOWN_REVS=2, INDEX_PULSE_CLKS=10.
module tb_drive_spindle_emulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        motor_on;
    logic        rpm_sel;
    logic        disk_present;
    logic        index_pulse;
    logic        index_n;
    logic        spinning;
    logic        at_speed;
    logic        ready;
    logic [15:0] rev_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected and observed index gaps, plus index_n low-run lengths
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] low_q[$];

    int unsigned cyc = 0;
    int unsigned spin_start = 0;
    int unsigned last_ref = 0;
    int unsigned at_delay = 0;
    int unsigned low_run = 0;
    int unsigned low_total = 0;
    logic        spin_prev = 1'b0;
    logic        at_prev = 1'b0;

    drive_spindle_emulator #(
        .CLK_FREQ        (1000),
        .SPINUP_REVS     (3),
        .SPINDOWN_REVS   (2),
        .INDEX_PULSE_CLKS(10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .motor_on    (motor_on),
        .rpm_sel     (rpm_sel),
        .disk_present(disk_present),
        .index_pulse (index_pulse),
        .index_n     (index_n),
        .spinning    (spinning),
        .at_speed    (at_speed),
        .ready       (ready),
        .rev_count   (rev_count),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: spin start, at_speed delay, index gaps, index_n widths
    always @(negedge clk) begin
        if (spinning && !spin_prev) begin
            spin_start = cyc;
            last_ref   = cyc;
        end
        if (at_speed && !at_prev) at_delay = cyc - spin_start;
        if (index_pulse) begin
            got_q.push_back(32'(cyc - last_ref));
            last_ref = cyc;
        end
        if (!index_n) begin
            low_run++;
            low_total++;
        end else if (low_run != 0) begin
            low_q.push_back(32'(low_run));
            low_run = 0;
        end
        spin_prev = spinning;
        at_prev   = at_speed;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for as many gaps as are queued in exp_q and compare in order
    task automatic expect_gaps(input string tag, input int budget);
        int n;
        int waited;
        logic [31:0] e;
        n = exp_q.size();
        waited = 0;
        while (got_q.size() < n && waited < budget) begin
            tick(1);
            waited++;
        end
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(n));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) check_eq(tag, got_q.pop_front(), e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        motor_on     = 1'b1;
        rpm_sel      = 1'b0;
        disk_present = 1'b1;

        // Reset held with motor_on asserted
        tick(5);
        check_eq("rst_index_pulse", 32'(index_pulse), 32'd0);
        check_eq("rst_index_n", 32'(index_n), 32'd1);
        check_eq("rst_spinning", 32'(spinning), 32'd0);
        check_eq("rst_at_speed", 32'(at_speed), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_rev_count", 32'(rev_count), 32'd0);
        reset_n = 1'b1;
        tick(1);
        check_eq("spin_after_rst", 32'(spinning), 32'd1);

        // Spin-up 350/300/250 then steady 200
        exp_q = '{32'd350, 32'd300, 32'd250, 32'd200, 32'd200};
        expect_gaps("spinup_gap", 2000);
        check_eq("at_speed_delay", 32'(at_delay), 32'd901);
        check_eq("at_speed_up", 32'(at_speed), 32'd1);
        check_eq("ready_up", 32'(ready), 32'd1);
        check_eq("rev_count_2", 32'(rev_count), 32'd2);
        check_eq("low_run_count", 32'(low_q.size()), 32'd4);
        while (low_q.size() > 0) check_eq("index_n_width", low_q.pop_front(), 32'd10);

        // Spin-down to stop: 200 (in progress), 250, 300, then no more pulses
        tick(20);
        motor_on = 1'b0;
        tick(2);
        check_eq("at_speed_down", 32'(at_speed), 32'd0);
        check_eq("ready_down", 32'(ready), 32'd0);
        exp_q = '{32'd200, 32'd250, 32'd300};
        expect_gaps("spindown_gap", 1500);
        check_eq("stopped", 32'(spinning), 32'd0);
        tick(500);
        check_eq("no_pulse_stopped", 32'(got_q.size()), 32'd0);
        check_eq("still_stopped", 32'(spinning), 32'd0);

        // Restart from STOPPED: full spin-up again, rev_count cleared
        motor_on = 1'b1;
        tick(2);
        check_eq("rev_count_clr", 32'(rev_count), 32'd0);
        exp_q = '{32'd350, 32'd300, 32'd250, 32'd200};
        expect_gaps("restart_gap", 2000);

        // Drop then re-assert during spin-down: 200, 250, then 300, 250, 200
        tick(20);
        motor_on = 1'b0;
        exp_q = '{32'd200, 32'd250};
        expect_gaps("partial_down_gap", 1000);
        tick(20);
        motor_on = 1'b1;
        exp_q = '{32'd300, 32'd250, 32'd200};
        expect_gaps("respin_gap", 1500);
        check_eq("respin_at_speed", 32'(at_speed), 32'd1);

        // RPM switch mid-revolution: current gap stays 200, then 166
        tick(50);
        rpm_sel = 1'b1;
        exp_q = '{32'd200, 32'd166, 32'd166};
        expect_gaps("rpm_gap", 1000);

        // rev_count saturation
        tick(30);
        force dut.rev_count_q = 16'hFFFE;
        tick(1);
        release dut.rev_count_q;
        exp_q = '{32'd166, 32'd166, 32'd166};
        expect_gaps("sat_gap", 1000);
        check_eq("rev_count_sat", 32'(rev_count), 32'h0000FFFF);

        // Asynchronous reset in the middle of an index pulse
        tick(3);
        check_eq("mid_index_low", 32'(index_n), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_index_n", 32'(index_n), 32'd1);
        check_eq("arst_index_pulse", 32'(index_pulse), 32'd0);
        check_eq("arst_spinning", 32'(spinning), 32'd0);
        check_eq("arst_rev_count", 32'(rev_count), 32'd0);
        check_eq("arst_ready", 32'(ready), 32'd0);

        // No media: no index activity, at_speed on schedule, ready gated
        disk_present = 1'b0;
        rpm_sel      = 1'b0;
        tick(2);
        got_q.delete();
        low_q.delete();
        low_total = 0;
        at_delay  = 0;
        reset_n   = 1'b1;
        for (int i = 0; i < 1200 && !at_speed; i++) tick(1);
        check_eq("nodisk_at_delay", 32'(at_delay), 32'd901);
        check_eq("nodisk_ready", 32'(ready), 32'd0);
        check_eq("nodisk_pulses", 32'(got_q.size()), 32'd0);
        check_eq("nodisk_index_low", 32'(low_total), 32'd0);
        check_eq("nodisk_index_n", 32'(index_n), 32'd1);
        disk_present = 1'b1;
        tick(1);
        check_eq("disk_ready", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
